// File: rtl/colnorm_sorter_if.sv
// colnorm_sorter_if: handshake bundle between the column-norm
// calculator, the sorter and the sorted-QR front end.
interface colnorm_sorter_if #(
  parameter int NORM_WL = 16,
  parameter int N_COL   = 8,
  parameter int IDX_WL  = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N_COL*NORM_WL-1:0] colnorm;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_COL*IDX_WL-1:0]  perm;
  logic [N_COL*NORM_WL-1:0] sorted_norm;
  logic                     busy;

  modport master (
    output in_valid, colnorm, out_ready,
    input  in_ready, out_valid, perm,
    input  sorted_norm, busy
  );

  modport slave (
    input  in_valid, colnorm, out_ready,
    output in_ready, out_valid, perm,
    output sorted_norm, busy
  );
endinterface

// File: rtl/colnorm_sorter.sv
// colnorm_sorter: captures one vector of column norms and selection-
// sorts it, one minimum per cycle, into an ascending permutation.
module colnorm_sorter #(
  parameter int NORM_WL = 16,
  parameter int N_COL   = 8,
  parameter int IDX_WL  = 3
) (
  input logic             clk,
  input logic             rst_n,
  colnorm_sorter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_WL-1:0] LAST =
    IDX_WL'(N_COL - 1);

  state_t              state;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;
  logic [IDX_WL-1:0]   count;
  logic [N_COL-1:0]    used;
  logic [NORM_WL-1:0]  norm_q [N_COL];
  logic [IDX_WL-1:0]   perm_q [N_COL];
  logic [NORM_WL-1:0]  sort_q [N_COL];

  logic [IDX_WL-1:0]   min_idx;
  logic [NORM_WL-1:0]  min_val;
  logic                found;

  // Lowest unused norm; strict '<' keeps the lowest index on ties.
  always_comb begin
    min_idx = '0;
    min_val = '1;
    found   = 1'b0;
    for (int i = 0; i < N_COL; i++) begin
      if (!used[i] &&
          (!found || norm_q[i] < min_val)) begin
        found   = 1'b1;
        min_idx = IDX_WL'(i);
        min_val = norm_q[i];
      end
    end
  end

  // Control FSM plus capture and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      count       <= '0;
      used        <= '0;
      for (int i = 0; i < N_COL; i++) begin
        norm_q[i] <= '0;
        perm_q[i] <= '0;
        sort_q[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < N_COL; i++)
              norm_q[i] <=
                bus.colnorm[i*NORM_WL +: NORM_WL];
            used       <= '0;
            count      <= '0;
            state      <= SORT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SORT: begin
          perm_q[count] <= min_idx;
          sort_q[count] <= min_val;
          used[min_idx] <= 1'b1;
          count         <= count + 1'b1;
          if (count == LAST) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

  for (genvar k = 0; k < N_COL; k++) begin : g_pack
    assign bus.perm[k*IDX_WL +: IDX_WL] = perm_q[k];
    assign bus.sorted_norm[k*NORM_WL +: NORM_WL] =
      sort_q[k];
  end

endmodule

// File: tb/tb_colnorm_sorter.sv
// tb_colnorm_sorter: directed table, corner sequences and random
// vectors checked against a rank-based stable sort model.
module tb_colnorm_sorter;

  localparam int NW = 16;
  localparam int NC = 8;
  localparam int IW = 3;

  typedef int arr8_t [8];
  typedef struct {
    logic [NC*NW-1:0] v;
    logic [NC*IW-1:0] p;
    logic [NC*NW-1:0] s;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  colnorm_sorter_if #(NW, NC, IW) bus ();

  colnorm_sorter #(
    .NORM_WL(NW), .N_COL(NC), .IDX_WL(IW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, a, e);
    end
  endtask

  function automatic logic [NC*NW-1:0] pk_n(input arr8_t a);
    logic [NC*NW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*NW +: NW] = 16'(a[i]);
    return r;
  endfunction

  function automatic logic [NC*IW-1:0] pk_p(input arr8_t a);
    logic [NC*IW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*IW +: IW] = 3'(a[i]);
    return r;
  endfunction

  // Stable sort by rank: position of column i is the number of
  // columns that must come before it.
  function automatic void ref_sort(input logic [NC*NW-1:0] v,
                                   output logic [NC*IW-1:0] p,
                                   output logic [NC*NW-1:0] s);
    int n [NC];
    for (int i = 0; i < NC; i++) n[i] = int'(v[i*NW +: NW]);
    p = '0;
    s = '0;
    for (int i = 0; i < NC; i++) begin
      int r = 0;
      for (int j = 0; j < NC; j++)
        if (n[j] < n[i] || (n[j] == n[i] && j < i)) r++;
      p[r*IW +: IW] = 3'(i);
      s[r*NW +: NW] = 16'(n[i]);
    end
  endfunction

  task automatic run_vec(input logic [NC*NW-1:0] v,
                         input int stall,
                         input bit scramble,
                         output logic [NC*IW-1:0] p,
                         output logic [NC*NW-1:0] s,
                         output int lat);
    int n = 0;
    p = '0;
    s = '0;
    lat = 0;
    @(negedge clk);
    bus.colnorm  = v;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!scramble) bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (scramble) bus.colnorm = {$urandom, $urandom,
                                   $urandom, $urandom};
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      chk("done_timeout", 0, 1);
      return;
    end
    p = bus.perm;
    s = bus.sorted_norm;
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      chk("stall_perm", bus.perm, p);
      chk("stall_sorted", bus.sorted_norm, s);
      chk("stall_ovalid", bus.out_valid, 1);
      chk("stall_iready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("hs_ovalid", bus.out_valid, 0);
    chk("hs_iready", bus.in_ready, 1);
    chk("hs_busy", bus.busy, 0);
  endtask

  vec_t tbl [5];
  logic [NC*IW-1:0] gp, ep;
  logic [NC*NW-1:0] gs, es, rv;
  int lat;

  initial begin
    tbl[0] = '{pk_n('{70,60,50,40,30,20,10,0}),
               pk_p('{7,6,5,4,3,2,1,0}),
               pk_n('{0,10,20,30,40,50,60,70})};
    tbl[1] = '{pk_n('{256,256,256,256,256,256,256,256}),
               pk_p('{0,1,2,3,4,5,6,7}),
               pk_n('{256,256,256,256,256,256,256,256})};
    tbl[2] = '{pk_n('{9,5,9,9,9,5,9,9}),
               pk_p('{1,5,0,2,3,4,6,7}),
               pk_n('{5,5,9,9,9,9,9,9})};
    tbl[3] = '{pk_n('{65535,65535,65535,0,
                      65535,65535,65535,65535}),
               pk_p('{3,0,1,2,4,5,6,7}),
               pk_n('{0,65535,65535,65535,
                      65535,65535,65535,65535})};
    tbl[4] = '{pk_n('{3,65535,3,1,65534,1,0,65535}),
               pk_p('{6,3,5,0,2,4,1,7}),
               pk_n('{0,1,1,3,3,65534,65535,65535})};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.colnorm   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ovalid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_perm", bus.perm, 0);
    chk("rst_sorted", bus.sorted_norm, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_iready", bus.in_ready, 1);

    for (int t = 0; t < 5; t++) begin
      run_vec(tbl[t].v, 0, 1'b0, gp, gs, lat);
      chk($sformatf("tbl%0d_perm", t), gp, tbl[t].p);
      chk($sformatf("tbl%0d_sorted", t), gs, tbl[t].s);
      chk($sformatf("tbl%0d_lat", t), lat, 8);
    end

    run_vec(tbl[0].v, 20, 1'b0, gp, gs, lat);
    chk("stall20_perm", gp, tbl[0].p);
    chk("stall20_sorted", gs, tbl[0].s);

    run_vec(tbl[4].v, 2, 1'b1, gp, gs, lat);
    chk("scramble_perm", gp, tbl[4].p);
    chk("scramble_sorted", gs, tbl[4].s);
    chk("scramble_lat", lat, 8);

    @(negedge clk);
    bus.colnorm  = tbl[0].v;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("abort_busy_pre", bus.busy, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ovalid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_perm", bus.perm, 0);
    chk("abort_sorted", bus.sorted_norm, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ovalid_rel", bus.out_valid, 0);
    rv = pk_n('{8,7,6,5,4,3,2,1});
    ref_sort(rv, ep, es);
    run_vec(rv, 0, 1'b0, gp, gs, lat);
    chk("post_rst_perm", gp, ep);
    chk("post_rst_sorted", gs, es);
    chk("post_rst_lat", lat, 8);

    for (int r = 0; r < 1000; r++) begin
      for (int i = 0; i < NC; i++)
        rv[i*NW +: NW] = (r % 2 == 0) ?
          16'($urandom_range(0, 7)) : 16'($urandom);
      ref_sort(rv, ep, es);
      run_vec(rv, $urandom_range(0, 3), 1'b0, gp, gs, lat);
      chk("rnd_perm", gp, ep);
      chk("rnd_sorted", gs, es);
      chk("rnd_lat", lat, 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
